// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, RV32I opcode/funct constants and decoded-field record shared by decoder and ALU.
package alu_pkg;

    typedef enum logic [5:0] {
        OP_ADDI    = 6'd0,
        OP_SLTI    = 6'd1,
        OP_SLTIU   = 6'd2,
        OP_XORI    = 6'd3,
        OP_ORI     = 6'd4,
        OP_ANDI    = 6'd5,
        OP_SLLI    = 6'd6,
        OP_SRLI    = 6'd7,
        OP_SRAI    = 6'd8,
        OP_ADD     = 6'd9,
        OP_SUB     = 6'd10,
        OP_SLL     = 6'd11,
        OP_SLT     = 6'd12,
        OP_SLTU    = 6'd13,
        OP_XOR     = 6'd14,
        OP_SRL     = 6'd15,
        OP_SRA     = 6'd16,
        OP_OR      = 6'd17,
        OP_AND     = 6'd18,
        ILLEGAL_OP = 6'd63
    } alu_op_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } dec_t;

    function automatic logic is_shift_imm(alu_op_e op);
        return op == OP_SLLI || op == OP_SRLI || op == OP_SRAI;
    endfunction

    // Shift immediates carry a 5-bit shamt, so they are zero-extended rather than sign-extended.
    function automatic logic [31:0] imm_of(logic [31:0] instr, alu_op_e op);
        return is_shift_imm(op) ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/alu_op_decoder_if.sv
// alu_op_decoder_if: instruction-in / decoded-fields-out handshake bundle.
interface alu_op_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, alu_op, rs1, rs2, rd, imm, use_imm, illegal
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, alu_op, rs1, rs2, rd, imm, use_imm, illegal
    );
endinterface

// File: rtl/alu_op_lut.sv
// alu_op_lut: combinational RV32I OP/OP-IMM to ALU op-code lookup with legality check.
module alu_op_lut
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output alu_op_e     alu_op_o,
    output logic        use_imm_o,
    output logic        illegal_o
);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    alu_op_e    imm_op;
    alu_op_e    reg_op;
    logic       imm_ok;
    logic       reg_ok;
    logic       unused_bits;

    assign opc         = instr_i[6:0];
    assign f3          = instr_i[14:12];
    assign f7          = instr_i[31:25];
    assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        imm_op    = f3 == F3_ADD  ? OP_ADDI  :
                    f3 == F3_SLT  ? OP_SLTI  :
                    f3 == F3_SLTU ? OP_SLTIU :
                    f3 == F3_XOR  ? OP_XORI  :
                    f3 == F3_OR   ? OP_ORI   :
                    f3 == F3_AND  ? OP_ANDI  :
                    f3 == F3_SLL  ? OP_SLLI  :
                    f7[5]         ? OP_SRAI  : OP_SRLI;
        imm_ok    = f3 == F3_SLL ? f7 == F7_BASE :
                    f3 == F3_SR  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
        reg_op    = f3 == F3_ADD  ? (f7[5] ? OP_SUB : OP_ADD) :
                    f3 == F3_SLL  ? OP_SLL  :
                    f3 == F3_SLT  ? OP_SLT  :
                    f3 == F3_SLTU ? OP_SLTU :
                    f3 == F3_XOR  ? OP_XOR  :
                    f3 == F3_SR   ? (f7[5] ? OP_SRA : OP_SRL) :
                    f3 == F3_OR   ? OP_OR   : OP_AND;
        // The alternate funct7 only selects SUB and SRA; any other pairing is reserved.
        reg_ok    = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
        illegal_o = !((opc == OPC_OP_IMM && imm_ok) || (opc == OPC_OP && reg_ok));
        use_imm_o = !illegal_o && opc == OPC_OP_IMM;
        alu_op_o  = illegal_o ? ILLEGAL_OP : opc == OPC_OP_IMM ? imm_op : reg_op;
    end
endmodule

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: single-entry registered RV32I ALU decoder with valid/ready handshake,
// flush and a wrapping count of legal instructions delivered downstream.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_decoder_if.slave  bus,
    output logic [CNT_W-1:0] dec_count
);
    alu_op_e          lut_op;
    logic             lut_use_imm;
    logic             lut_illegal;
    dec_t             new_dec;
    dec_t             dec_d;
    dec_t             dec_q;
    logic             valid_d;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             deliver;

    alu_op_lut u_lut (
        .instr_i   (bus.instr),
        .alu_op_o  (lut_op),
        .use_imm_o (lut_use_imm),
        .illegal_o (lut_illegal)
    );

    assign bus.in_ready = !valid_q || bus.out_ready;

    always_comb begin
        new_dec         = '0;
        new_dec.alu_op  = lut_op;
        new_dec.rs1     = bus.instr[19:15];
        new_dec.rs2     = bus.instr[24:20];
        new_dec.rd      = bus.instr[11:7];
        new_dec.imm     = imm_of(bus.instr, lut_op);
        new_dec.use_imm = lut_use_imm;
        new_dec.illegal = lut_illegal;
        // Flush outranks both sides of the handshake: nothing enters, nothing is counted.
        accept          = bus.in_valid && bus.in_ready && !bus.flush;
        deliver         = valid_q && bus.out_ready && !bus.flush;
        valid_d         = !bus.flush && (accept || (valid_q && !bus.out_ready));
        dec_d           = accept ? new_dec : dec_q;
        cnt_d           = (deliver && !dec_q.illegal) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.alu_op    = dec_q.alu_op;
    assign bus.rs1       = dec_q.rs1;
    assign bus.rs2       = dec_q.rs2;
    assign bus.rd        = dec_q.rd;
    assign bus.imm       = dec_q.imm;
    assign bus.use_imm   = dec_q.use_imm;
    assign bus.illegal   = dec_q.illegal;
    assign dec_count     = cnt_q;
endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: directed vectors with a queue scoreboard checked by a separate monitor.
module tb_alu_op_decoder;
    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ui;
        logic        ill;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] dec_count;
    logic [15:0] exp_cnt = 16'd0;
    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    exp_t        pend;

    alu_op_decoder_if bus ();

    alu_op_decoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dec_count (dec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: a held word is either discarded by flush or consumed when out_ready is high.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (bus.flush) begin
                if (q.size() != 0) e = q.pop_front();
            end else if (bus.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected output: got alu_op %0d want none", bus.alu_op);
                end else begin
                    e = q.pop_front();
                    chk("alu_op", 32'(bus.alu_op), 32'(e.op));
                    chk("rs1", 32'(bus.rs1), 32'(e.rs1));
                    chk("rs2", 32'(bus.rs2), 32'(e.rs2));
                    chk("rd", 32'(bus.rd), 32'(e.rd));
                    chk("use_imm", 32'(bus.use_imm), 32'(e.ui));
                    chk("illegal", 32'(bus.illegal), 32'(e.ill));
                    if (e.ui) chk("imm", bus.imm, e.imm);
                    chk("dec_count_at_delivery", 32'(dec_count), 32'(exp_cnt));
                    if (!e.ill) exp_cnt++;
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        if (rst_n && bus.in_valid && bus.in_ready && !bus.flush) q.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] w, input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic ui, input logic ill);
        bus.in_valid = 1'b1;
        bus.instr    = w;
        pend         = '{op, r1, r2, rd, imm, ui, ill};
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_alu_op", 32'(bus.alu_op), 0);
        chk("rst_rs1", 32'(bus.rs1), 0);
        chk("rst_rs2", 32'(bus.rs2), 0);
        chk("rst_rd", 32'(bus.rd), 0);
        chk("rst_imm", bus.imm, 0);
        chk("rst_use_imm", 32'(bus.use_imm), 0);
        chk("rst_illegal", 32'(bus.illegal), 0);
        chk("rst_dec_count", 32'(dec_count), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        put(32'h00500093, 6'd0, 5'd0, 5'd5, 5'd1, 32'd5, 1'b1, 1'b0);
        cyc();
        idle();
        chk("addi_out_valid", 32'(bus.out_valid), 1);
        chk("addi_alu_op", 32'(bus.alu_op), 0);
        chk("addi_imm", bus.imm, 5);
        cyc();
        chk("addi_dec_count", 32'(dec_count), 1);
        chk("addi_drained", 32'(bus.out_valid), 0);

        put(32'h40208033, 6'd10, 5'd1, 5'd2, 5'd0, 32'h402, 1'b0, 1'b0); cyc();
        put(32'h4020D033, 6'd16, 5'd1, 5'd2, 5'd0, 32'h402, 1'b0, 1'b0); cyc();
        put(32'h4020C033, 6'd63, 5'd1, 5'd2, 5'd0, 32'h402, 1'b0, 1'b1); cyc();
        put(32'h00002083, 6'd63, 5'd0, 5'd0, 5'd1, 32'h0,   1'b0, 1'b1); cyc();
        put(32'h40725193, 6'd8,  5'd4, 5'd7, 5'd3, 32'd7,   1'b1, 1'b0); cyc();
        put(32'hFFF30293, 6'd0,  5'd6, 5'd31, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b0); cyc();
        put(32'h40001093, 6'd63, 5'd0, 5'd0, 5'd1, 32'h400, 1'b0, 1'b1); cyc();
        put(32'h009473B3, 6'd18, 5'd8, 5'd9, 5'd7, 32'h9,   1'b0, 1'b0); cyc();
        put(32'h7FF1C113, 6'd3,  5'd3, 5'd31, 5'd2, 32'h7FF, 1'b1, 1'b0); cyc();
        put(32'h02208033, 6'd63, 5'd1, 5'd2, 5'd0, 32'h22,  1'b0, 1'b1); cyc();
        put(32'h003130B3, 6'd13, 5'd2, 5'd3, 5'd1, 32'h3,   1'b0, 1'b0); cyc();
        idle();
        cyc();
        chk("stream_dec_count", 32'(dec_count), 8);

        bus.out_ready = 1'b0;
        put(32'h009473B3, 6'd18, 5'd8, 5'd9, 5'd7, 32'h9, 1'b0, 1'b0);
        cyc();
        put(32'h7FF1C113, 6'd3, 5'd3, 5'd31, 5'd2, 32'h7FF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_out_valid", 32'(bus.out_valid), 1);
            chk("stall_alu_op", 32'(bus.alu_op), 18);
            chk("stall_rd", 32'(bus.rd), 7);
        end
        bus.out_ready = 1'b1;
        cyc();
        idle();
        chk("after_stall_alu_op", 32'(bus.alu_op), 3);
        chk("after_stall_out_valid", 32'(bus.out_valid), 1);
        cyc();
        chk("after_stall_drained", 32'(bus.out_valid), 0);
        chk("after_stall_queue", 32'(q.size()), 0);

        bus.out_ready = 1'b0;
        put(32'h003130B3, 6'd13, 5'd2, 5'd3, 5'd1, 32'h3, 1'b0, 1'b0);
        cyc();
        put(32'hFFF30293, 6'd0, 5'd6, 5'd31, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b0);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        idle();
        chk("flush_out_valid", 32'(bus.out_valid), 0);
        cyc();
        chk("flush_dropped_input", 32'(bus.out_valid), 0);
        chk("flush_dec_count", 32'(dec_count), 10);
        chk("flush_queue", 32'(q.size()), 0);

        put(32'h00500093, 6'd0, 5'd0, 5'd5, 5'd1, 32'd5, 1'b1, 1'b0);
        cyc();
        put(32'h40208033, 6'd10, 5'd1, 5'd2, 5'd0, 32'h402, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 0);
        chk("async_rst_dec_count", 32'(dec_count), 0);
        chk("async_rst_alu_op", 32'(bus.alu_op), 0);
        q.delete();
        exp_cnt = 16'd0;
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;

        put(32'h00500093, 6'd0, 5'd0, 5'd5, 5'd1, 32'd5, 1'b1, 1'b0);
        repeat (65535) cyc();
        idle();
        cyc();
        chk("count_ffff", 32'(dec_count), 32'hFFFF);
        put(32'h003130B3, 6'd13, 5'd2, 5'd3, 5'd1, 32'h3, 1'b0, 1'b0);
        cyc();
        idle();
        cyc();
        chk("count_wrap", 32'(dec_count), 0);
        chk("final_queue", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
